// File: rtl/sipo_loader_if.sv
// Serial-in word loader bus: serial source and
// word consumer on one side, loader on the other.
interface sipo_loader_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             sin;
   logic             sin_valid;
   logic [0:WIDTH-1] word;
   logic             word_valid;
   logic             word_ack;
   logic             busy;
   logic [4:0]       bit_cnt;
   logic             overrun;

   modport master (
      output start, sin, sin_valid, word_ack,
      input  word, word_valid, busy,
      input  bit_cnt, overrun
   );

   modport slave (
      input  start, sin, sin_valid, word_ack,
      output word, word_valid, busy,
      output bit_cnt, overrun
   );
endinterface

// File: rtl/sipo_loader.sv
// Serial-to-parallel word assembler with
// IDLE/SHIFT/HOLD control and a sticky overrun flag.
module sipo_loader #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic         clk,
   input  logic         rst,
   sipo_loader_if.slave bus
);
   localparam int            IW   = $clog2(WIDTH);
   localparam logic [4:0]    LAST = 5'(WIDTH - 1);
   localparam logic [IW-1:0] TOP  = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;

   state_t           state;
   logic [0:WIDTH-1] word_q;
   logic             word_valid_q;
   logic             busy_q;
   logic             overrun_q;
   logic [4:0]       bit_cnt_q;
   logic [IW-1:0]    pos;

   // word[0] is the MSB; LSB-first streams fill from the far end
   always_comb begin
      pos = bit_cnt_q[IW-1:0];
      if (MSB_FIRST == 0) pos = TOP - bit_cnt_q[IW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         bit_cnt_q    <= '0;
         overrun_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= SHIFT;
                  busy_q    <= 1'b1;
                  bit_cnt_q <= '0;
                  overrun_q <= 1'b0;
               end
            end
            SHIFT: begin
               if (bus.start) begin
                  bit_cnt_q <= '0;
               end else if (bus.sin_valid) begin
                  word_q[pos] <= bus.sin;
                  bit_cnt_q   <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == LAST) begin
                     state        <= HOLD;
                     busy_q       <= 1'b0;
                     word_valid_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               // start is deliberately ignored until IDLE
               if (bus.sin_valid) overrun_q <= 1'b1;
               if (bus.word_ack) begin
                  state        <= IDLE;
                  word_valid_q <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               busy_q       <= 1'b0;
               word_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.word       = word_q;
   assign bus.word_valid = word_valid_q;
   assign bus.busy       = busy_q;
   assign bus.bit_cnt    = bit_cnt_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_loader.sv
// Bench for sipo_loader: two instances (MSB and
// LSB first) driven alike, words checked by scoreboard.
module tb_sipo_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sipo_loader_if #(.WIDTH(4)) ia ();
   sipo_loader_if #(.WIDTH(4)) ib ();

   sipo_loader #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ia)
   );
   sipo_loader #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst(rst), .bus(ib)
   );

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int t0;
   logic [0:3] qa[$];
   logic [0:3] qb[$];
   logic wva_d = 1'b0;
   logic wvb_d = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ia.word_valid && !wva_d) begin
         rise_cyc = cyc;
         if (qa.size() == 0) chk("sb_a_unexp", 1, 0);
         else chk("sb_a_word", 32'(ia.word), 32'(qa.pop_front()));
      end
      if (ib.word_valid && !wvb_d) begin
         if (qb.size() == 0) chk("sb_b_unexp", 1, 0);
         else chk("sb_b_word", 32'(ib.word), 32'(qb.pop_front()));
      end
      wva_d = ia.word_valid;
      wvb_d = ib.word_valid;
   end

   task automatic drv(input logic st, input logic sv,
                      input logic s, input logic ack);
      ia.start = st; ia.sin_valid = sv;
      ia.sin = s;    ia.word_ack = ack;
      ib.start = st; ib.sin_valid = sv;
      ib.sin = s;    ib.word_ack = ack;
      @(negedge clk);
   endtask

   task automatic push(input logic [0:3] b);
      logic [0:3] e;
      for (int i = 0; i < 4; i++) e[3-i] = b[i];
      qa.push_back(b);
      qb.push_back(e);
   endtask

   task automatic load(input logic [0:3] b, input int maxgap);
      push(b);
      drv(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(maxgap, 0)) drv(0, 0, 0, 0);
         drv(0, 1, b[i], 0);
      end
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_word"}, 32'(ia.word), 0);
      chk({tag, "_wordb"}, 32'(ib.word), 0);
      chk({tag, "_wv"}, 32'(ia.word_valid), 0);
      chk({tag, "_busy"}, 32'(ia.busy), 0);
      chk({tag, "_cnt"}, 32'(ia.bit_cnt), 0);
      chk({tag, "_ovr"}, 32'(ia.overrun), 0);
   endtask

   int vp[7] = '{1, 0, 0, 1, 1, 0, 1};
   int sp[7] = '{0, 0, 0, 1, 1, 0, 0};
   int ec[7] = '{1, 1, 1, 2, 3, 3, 4};
   logic [0:3] rw;

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 0);
      drv(0, 0, 0, 0);
      zero_chk("rst");
      rst = 1'b0;
      drv(0, 0, 0, 1);
      chk("idle_ack_busy", 32'(ia.busy), 0);
      chk("idle_ack_wv", 32'(ia.word_valid), 0);

      t0 = cyc;
      load(4'b1011, 0);
      chk("t1_word", 32'(ia.word), 32'(4'b1011));
      chk("t1_wordb", 32'(ib.word), 32'(4'b1101));
      chk("t1_wv", 32'(ia.word_valid), 1);
      chk("t1_busy", 32'(ia.busy), 0);
      chk("t1_cnt", 32'(ia.bit_cnt), 4);
      drv(0, 0, 0, 0);
      chk("t1_lat", 32'(rise_cyc - t0), 5);
      chk("t1_hold_wv", 32'(ia.word_valid), 1);
      drv(0, 0, 0, 1);
      chk("t1_ack_wv", 32'(ia.word_valid), 0);
      chk("t1_ack_busy", 32'(ia.busy), 0);
      chk("t1_keep", 32'(ia.word), 32'(4'b1011));

      push(4'b0110);
      drv(1, 0, 0, 0);
      chk("t3_busy", 32'(ia.busy), 1);
      chk("t3_cnt0", 32'(ia.bit_cnt), 0);
      for (int i = 0; i < 7; i++) begin
         drv(0, 1'(vp[i]), 1'(sp[i]), 0);
         chk($sformatf("t3_cnt%0d", i + 1),
             32'(ia.bit_cnt), 32'(ec[i]));
      end
      chk("t3_wv", 32'(ia.word_valid), 1);
      drv(0, 0, 0, 1);

      push(4'b1111);
      drv(1, 0, 0, 0);
      drv(0, 1, 1, 0);
      drv(0, 1, 0, 0);
      chk("t4_cnt2", 32'(ia.bit_cnt), 2);
      drv(1, 1, 1, 0);
      chk("t4_restart_cnt", 32'(ia.bit_cnt), 0);
      chk("t4_restart_busy", 32'(ia.busy), 1);
      repeat (4) drv(0, 1, 1, 0);
      chk("t4_word", 32'(ia.word), 32'(4'b1111));
      drv(0, 0, 0, 1);

      load(4'b0010, 0);
      drv(1, 1, 1, 0);
      chk("t5_ovr", 32'(ia.overrun), 1);
      chk("t5_word", 32'(ia.word), 32'(4'b0010));
      chk("t5_wordb", 32'(ib.word), 32'(4'b0100));
      drv(1, 0, 0, 0);
      drv(1, 0, 0, 0);
      chk("t5_hold_wv", 32'(ia.word_valid), 1);
      chk("t5_hold_busy", 32'(ia.busy), 0);
      chk("t5_hold_word", 32'(ia.word), 32'(4'b0010));
      chk("t5_ovr_stick", 32'(ia.overrun), 1);
      drv(1, 0, 0, 1);
      chk("t5_ack_wv", 32'(ia.word_valid), 0);
      chk("t5_ack_busy", 32'(ia.busy), 0);
      chk("t5_ack_ovr", 32'(ia.overrun), 1);
      drv(0, 0, 0, 0);
      chk("t5_idle_busy", 32'(ia.busy), 0);
      push(4'b1100);
      drv(1, 0, 0, 0);
      chk("t5_ovr_clr", 32'(ia.overrun), 0);
      chk("t5_busy", 32'(ia.busy), 1);
      drv(0, 1, 1, 0);
      drv(0, 1, 1, 0);
      drv(0, 1, 0, 0);
      drv(0, 1, 0, 0);
      drv(0, 0, 0, 1);

      drv(1, 0, 0, 0);
      repeat (3) drv(0, 1, 1, 0);
      chk("t6_cnt3", 32'(ia.bit_cnt), 3);
      rst = 1'b1;
      drv(1, 1, 1, 1);
      rst = 1'b0;
      zero_chk("t6");
      load(4'b0101, 1);
      chk("t6_word", 32'(ia.word), 32'(4'b0101));
      chk("t6_wordb", 32'(ib.word), 32'(4'b1010));
      drv(0, 0, 0, 1);

      for (int n = 0; n < 6; n++) begin
         rw = 4'($urandom_range(15, 0));
         load(rw, 2);
         repeat ($urandom_range(2, 0)) drv(0, 0, 0, 0);
         drv(0, 0, 0, 1);
      end

      drv(0, 0, 0, 0);
      drv(0, 0, 0, 0);
      chk("sb_a_empty", 32'(qa.size()), 0);
      chk("sb_b_empty", 32'(qb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
